// File: rtl/qupls_fu_dispatch.sv
// Functional-unit dispatch sequencer: accepts one op from the scheduler, runs it for a
// fixed latency, then holds the result until the writeback arbiter takes it.
module qupls_fu_dispatch #(
   parameter int LAT_W  = 6,
   parameter int RNDX_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [RNDX_W-1:0] rndx,
   input  logic              rndxv,
   input  logic [LAT_W-1:0]  op_lat,
   input  logic              flush,
   input  logic              wb_ack,
   output logic              idle,
   output logic              ex_v,
   output logic [RNDX_W-1:0] ex_rndx,
   output logic              wb_v,
   output logic [RNDX_W-1:0] wb_rndx,
   output logic              issue_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_t;

   state_t           state;
   logic [LAT_W-1:0] cnt;
   logic             accept;

   // A WB slot being acked this cycle frees the unit, so the scheduler sees no bubble.
   always_comb begin
      idle   = (state == IDLE) || ((state == WB) && wb_ack && !flush);
      accept = idle && rndxv && !flush;
   end

   // Sequencer state, latency counter and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         ex_v      <= 1'b0;
         wb_v      <= 1'b0;
         ex_rndx   <= '0;
         wb_rndx   <= '0;
         issue_err <= 1'b0;
      end else begin
         ex_v <= accept;
         if (rndxv && !idle) begin
            issue_err <= 1'b1;
         end
         if (flush) begin
            state <= IDLE;
            wb_v  <= 1'b0;
         end else if (accept) begin
            state   <= EXEC;
            cnt     <= op_lat;
            ex_rndx <= rndx;
            wb_rndx <= rndx;
            wb_v    <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  wb_v <= 1'b0;
               end
               EXEC: begin
                  if (cnt == '0) begin
                     state <= WB;
                     wb_v  <= 1'b1;
                  end else begin
                     cnt <= cnt - LAT_W'(1);
                  end
               end
               WB: begin
                  if (wb_ack) begin
                     state <= IDLE;
                     wb_v  <= 1'b0;
                  end else begin
                     wb_v <= 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  wb_v  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
